operand_sel_pipe: RTL

//   Parametrised N-to-1 operand selector with a registered, back-pressured output stage.

---
 rtl/risc_pkg.sv | 15 +
 rtl/mux_n_to_1.sv | 26 ++
 rtl/operand_sel_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared core definitions: default operand geometry
// and the operand-stage occupancy encoding.
package risc_pkg;

   localparam int XLEN         = 32;
   localparam int NUM_OPND_SRC = 3;

   // Number of valid entries held in main + skid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

endpackage

// File: rtl/mux_n_to_1.sv
// Combinational N:1 source selector.
// Out-of-range select yields zero data and err=1.
module mux_n_to_1 #(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 3,
   localparam int SEL_W  = $clog2(NUM_SRC)
) (
   output logic [WIDTH-1:0]         out,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_SRC*WIDTH-1:0] in_bus,
   output logic                     err
);

   // Zero/err default; a matching index overrides it.
   always_comb begin
      out = '0;
      err = 1'b1;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (sel == SEL_W'(k)) begin
            out = in_bus[k*WIDTH +: WIDTH];
            err = 1'b0;
         end
      end
   end

endmodule

// File: rtl/operand_sel_pipe.sv
// Operand selector with a registered output stage,
// 2-entry skid buffer and saturating select-error counter.
module operand_sel_pipe
   import risc_pkg::*;
#(
   parameter int WIDTH     = XLEN,
   parameter int NUM_SRC   = NUM_OPND_SRC,
   parameter int ERR_CNT_W = 8,
   localparam int SEL_W    = $clog2(NUM_SRC)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_SRC*WIDTH-1:0] src_bus,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_sel_err,
   output logic [ERR_CNT_W-1:0]     err_count
);

   skid_state_e      state;
   skid_state_e      state_n;
   logic [WIDTH-1:0] mux_data;
   logic             mux_err;
   logic [WIDTH-1:0] main_data;
   logic             main_err;
   logic [WIDTH-1:0] skid_data;
   logic             skid_err;
   logic             in_xfer;
   logic             out_xfer;

   mux_n_to_1 #(
      .WIDTH   (WIDTH),
      .NUM_SRC (NUM_SRC)
   ) u_mux (
      .out    (mux_data),
      .sel    (sel),
      .in_bus (src_bus),
      .err    (mux_err)
   );

   // in_ready depends only on registered state, never on out_ready.
   assign in_ready    = !rst && (state != ST_FULL);
   assign out_valid   = (state != ST_EMPTY);
   assign out_data    = main_data;
   assign out_sel_err = main_err;
   assign in_xfer     = in_valid && in_ready;
   assign out_xfer    = out_valid && out_ready;

   // Occupancy register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_EMPTY;
      else     state <= state_n;
   end

   // Next occupancy from the two handshakes.
   always_comb begin
      state_n = state;
      unique case (state)
         ST_EMPTY: if (in_xfer) state_n = ST_ONE;
         ST_ONE: begin
            if (in_xfer && !out_xfer)      state_n = ST_FULL;
            else if (!in_xfer && out_xfer) state_n = ST_EMPTY;
         end
         ST_FULL: if (out_xfer) state_n = ST_ONE;
         default: state_n = ST_EMPTY;
      endcase
   end

   // Main/skid data movement; main always holds the oldest beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_data <= '0;
         main_err  <= 1'b0;
         skid_data <= '0;
         skid_err  <= 1'b0;
      end else begin
         unique case (state)
            ST_EMPTY: begin
               if (in_xfer) begin
                  main_data <= mux_data;
                  main_err  <= mux_err;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_data <= mux_data;
                  main_err  <= mux_err;
               end else if (in_xfer) begin
                  skid_data <= mux_data;
                  skid_err  <= mux_err;
               end
            end
            ST_FULL: begin
               if (out_xfer) begin
                  main_data <= skid_data;
                  main_err  <= skid_err;
               end
            end
            default: ;
         endcase
      end
   end

   // Count accepted illegal-select beats, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
      end else if (in_xfer && mux_err &&
                   (err_count != {ERR_CNT_W{1'b1}})) begin
         err_count <= err_count + ERR_CNT_W'(1);
      end
   end

endmodule
